// File: rtl/coproc_pkg.sv
// Shared types and character constants for the UART command link (encoder and decoder).
package coproc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      WAIT = 2'd3
   } enc_state_t;

   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_A  = 8'h41;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   // Upper-case hex digit for one nibble; the 8-bit add cannot overflow.
   function automatic logic [7:0] nib2ascii(input logic [3:0] n);
      logic [7:0] c;
      if (n < 4'd10) begin
         c = ASCII_0 + {4'h0, n};
      end else begin
         c = ASCII_A + ({4'h0, n} - 8'd10);
      end
      return c;
   endfunction

endpackage

// File: rtl/response_encoder.sv
// Serialises one coprocessor result word to the UART TX as upper-case hex, MSB nibble first,
// followed by a terminator byte.
module response_encoder
   import coproc_pkg::*;
#(
   parameter int         DATA_W = 16,
   parameter logic [7:0] TERM   = ASCII_LF
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] result_data,
   input  logic              result_valid,
   output logic              result_ready,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_busy,
   output logic              encoder_busy
);

   localparam int NCHAR = DATA_W / 4;
   localparam int IDX_W = $clog2(NCHAR + 1);

   enc_state_t        state_r, next_state_s;
   logic [IDX_W-1:0]  idx_r, idx_s;
   logic [DATA_W-1:0] shadow_r, shadow_s;
   logic              tx_start_s;
   logic [7:0]        tx_data_s;
   logic [DATA_W-1:0] shifted_s;
   logic [3:0]        nib_s;
   logic [7:0]        char_s;

   assign result_ready = (state_r == IDLE);
   assign encoder_busy = ~result_ready;

   // Character for the current index: shifting left brings the selected nibble to the top.
   always_comb begin
      shifted_s = shadow_r << {idx_r, 2'b00};
      nib_s     = shifted_s[DATA_W-1 -: 4];
      if (idx_r == IDX_W'(NCHAR)) begin
         char_s = TERM;
      end else begin
         char_s = nib2ascii(nib_s);
      end
   end

   // Next-state logic; GAP deliberately ignores tx_busy to cover the TX busy-rise latency.
   always_comb begin
      next_state_s = state_r;
      idx_s        = idx_r;
      shadow_s     = shadow_r;
      tx_start_s   = 1'b0;
      tx_data_s    = tx_data;
      case (state_r)
         IDLE: begin
            if (result_valid) begin
               shadow_s     = result_data;
               idx_s        = {IDX_W{1'b0}};
               next_state_s = SEND;
            end else begin
               next_state_s = IDLE;
            end
         end
         SEND: begin
            if (!tx_busy) begin
               tx_start_s   = 1'b1;
               tx_data_s    = char_s;
               next_state_s = GAP;
            end else begin
               next_state_s = SEND;
            end
         end
         GAP: begin
            next_state_s = WAIT;
         end
         WAIT: begin
            if (tx_busy) begin
               next_state_s = WAIT;
            end else if (idx_r == IDX_W'(NCHAR)) begin
               next_state_s = IDLE;
            end else begin
               idx_s        = idx_r + IDX_W'(1);
               next_state_s = SEND;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // State, index, shadow word and registered TX outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         idx_r    <= {IDX_W{1'b0}};
         shadow_r <= {DATA_W{1'b0}};
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         state_r  <= next_state_s;
         idx_r    <= idx_s;
         shadow_r <= shadow_s;
         tx_start <= tx_start_s;
         tx_data  <= tx_data_s;
      end
   end

endmodule
